// File: rtl/hpdcache_tb_perf_counter_collector.sv
// Per-cycle event counters with sticky overflow, plus a frozen snapshot serialised as a valid/ready stream.
// Optional build macro HPDCACHE_TB_PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module hpdcache_tb_perf_counter_collector #(
   parameter int unsigned NEVT  = 8,
   parameter int unsigned CNT_W = 32,
   parameter int unsigned ID_W  = (NEVT > 1) ? $clog2(NEVT) : 1
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic [NEVT-1:0]  evt_i,
   input  logic             clear_i,
   input  logic             snap_req_i,
   output logic             snap_busy_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [ID_W-1:0]  out_id_o,
   output logic [CNT_W-1:0] out_cnt_o,
   output logic             out_ovf_o,
   output logic             out_last_o
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NEVT - 1);

   logic [CNT_W-1:0] cnt_reg        [NEVT];
   logic [CNT_W-1:0] shadow_cnt_reg [NEVT];
   logic [NEVT-1:0]  ovf_reg;
   logic [NEVT-1:0]  shadow_ovf_reg;
   state_t           state_reg;
   logic [ID_W-1:0]  idx_reg;
   logic             snap_take;
   logic             stream;
   logic             last_entry;

   assign stream     = (state_reg == STREAM);
   assign snap_take  = (state_reg == IDLE) && snap_req_i;
   assign last_entry = (idx_reg == LAST_IDX);

   genvar gi;
   generate
      for (gi = 0; gi < NEVT; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (!rst_ni) begin
               cnt_reg[gi] <= '0;
               ovf_reg[gi] <= 1'b0;
            end else if (clear_i) begin
               cnt_reg[gi] <= '0;
               ovf_reg[gi] <= 1'b0;
            end else if (evt_i[gi]) begin
               if (&cnt_reg[gi]) begin
`ifdef HPDCACHE_TB_PERF_SATURATE_EN
                  cnt_reg[gi] <= cnt_reg[gi];
`else
                  cnt_reg[gi] <= '0;
`endif
                  ovf_reg[gi] <= 1'b1;
               end else begin
                  cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
               end
            end
         end

         // Shadow captures the pre-edge live values, so same-cycle events and clears are excluded.
         always_ff @(posedge clk) begin
            if (!rst_ni) begin
               shadow_cnt_reg[gi] <= '0;
               shadow_ovf_reg[gi] <= 1'b0;
            end else if (snap_take) begin
               shadow_cnt_reg[gi] <= cnt_reg[gi];
               shadow_ovf_reg[gi] <= ovf_reg[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (snap_req_i) begin
                  idx_reg   <= '0;
                  state_reg <= STREAM;
               end
            end
            STREAM: begin
               if (out_ready_i) begin
                  if (last_entry) begin
                     idx_reg   <= '0;
                     state_reg <= IDLE;
                  end else begin
                     idx_reg <= idx_reg + 1'b1;
                  end
               end
            end
            default: begin
               idx_reg   <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign snap_busy_o = stream;
   assign out_valid_o = stream;
   assign out_id_o    = idx_reg;
   assign out_cnt_o   = stream ? shadow_cnt_reg[idx_reg] : '0;
   assign out_ovf_o   = stream & shadow_ovf_reg[idx_reg];
   assign out_last_o  = stream & last_entry;

endmodule

// File: tb/tb_hpdcache_tb_perf_counter_collector.sv
// Bench for hpdcache_tb_perf_counter_collector (NEVT=4, CNT_W=8): table vectors, directed sequences,
// and random stimulus against an abstract count/snapshot-queue reference model.
module tb_hpdcache_tb_perf_counter_collector;

   localparam int NEVT  = 4;
   localparam int CNT_W = 8;
   localparam int ID_W  = 2;
   localparam int MAXV  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_ni = 1'b0;
   logic [NEVT-1:0]  evt_i = '0;
   logic             clear_i = 1'b0;
   logic             snap_req_i = 1'b0;
   logic             snap_busy_o;
   logic             out_valid_o;
   logic             out_ready_i = 1'b0;
   logic [ID_W-1:0]  out_id_o;
   logic [CNT_W-1:0] out_cnt_o;
   logic             out_ovf_o;
   logic             out_last_o;

   always #5 clk = ~clk;

   hpdcache_tb_perf_counter_collector #(.NEVT(NEVT), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
      .clk         (clk),
      .rst_ni      (rst_ni),
      .evt_i       (evt_i),
      .clear_i     (clear_i),
      .snap_req_i  (snap_req_i),
      .snap_busy_o (snap_busy_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_id_o    (out_id_o),
      .out_cnt_o   (out_cnt_o),
      .out_ovf_o   (out_ovf_o),
      .out_last_o  (out_last_o)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: live counts per event, and the pending snapshot as a queue of entries.
   typedef struct {
      int id;
      int cnt;
      bit ovf;
   } ent_t;

   int   mcnt [NEVT];
   bit   movf [NEVT];
   ent_t mq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_cycle(input logic [NEVT-1:0] e, input logic c, input logic r,
                              input logic rdy, input logic rn);
      if (!rn) begin
         foreach (mcnt[k]) begin
            mcnt[k] = 0;
            movf[k] = 0;
         end
         mq.delete();
         return;
      end
      if (mq.size() != 0) begin
         if (rdy) void'(mq.pop_front());
      end else if (r) begin
         for (int k = 0; k < NEVT; k++) begin
            ent_t en;
            en.id  = k;
            en.cnt = mcnt[k];
            en.ovf = movf[k];
            mq.push_back(en);
         end
      end
      for (int k = 0; k < NEVT; k++) begin
         if (c) begin
            mcnt[k] = 0;
            movf[k] = 0;
         end else if (e[k]) begin
            if (mcnt[k] == MAXV) begin
`ifdef HPDCACHE_TB_PERF_SATURATE_EN
               mcnt[k] = MAXV;
`else
               mcnt[k] = 0;
`endif
               movf[k] = 1;
            end else begin
               mcnt[k] = mcnt[k] + 1;
            end
         end
      end
   endtask

   // One clock: drive on the falling edge, advance the model, check #1 after the rising edge.
   task automatic step(input logic [NEVT-1:0] e, input logic c, input logic r,
                       input logic rdy, input logic rn);
      @(negedge clk);
      evt_i       = e;
      clear_i     = c;
      snap_req_i  = r;
      out_ready_i = rdy;
      rst_ni      = rn;
      model_cycle(e, c, r, rdy, rn);
      @(posedge clk);
      #1;
      chk("valid", {31'd0, out_valid_o}, {31'd0, mq.size() != 0});
      chk("busy", {31'd0, snap_busy_o}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("id", 32'(out_id_o), 32'(mq[0].id));
         chk("cnt", 32'(out_cnt_o), 32'(mq[0].cnt));
         chk("ovf", {31'd0, out_ovf_o}, {31'd0, mq[0].ovf});
         chk("last", {31'd0, out_last_o}, {31'd0, mq[0].id == NEVT - 1});
      end
   endtask

   task automatic drain();
      for (int i = 0; i < NEVT + 1; i++) step('0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   typedef struct {
      logic [NEVT-1:0]  evt;
      logic             req;
      logic             rdy;
      logic             ev;
      logic [ID_W-1:0]  eid;
      logic [CNT_W-1:0] ecnt;
      logic             elast;
   } vec_t;

   vec_t tbl [10];

   initial begin
      for (int i = 0; i < 5; i++) tbl[i] = '{4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0};
      tbl[5] = '{4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 8'd0, 1'b0};
      tbl[6] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 8'd0, 1'b0};
      tbl[7] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 8'd5, 1'b0};
      tbl[8] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 8'd0, 1'b1};
      tbl[9] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0};

      // Reset state
      step('0, 1'b0, 1'b0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_busy", {31'd0, snap_busy_o}, 32'd0);
      chk("rst_id", 32'(out_id_o), 32'd0);
      chk("rst_cnt", 32'(out_cnt_o), 32'd0);
      chk("rst_ovf", {31'd0, out_ovf_o}, 32'd0);
      chk("rst_last", {31'd0, out_last_o}, 32'd0);

      // Basic snapshot, table-driven
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].evt, 1'b0, tbl[i].req, tbl[i].rdy, 1'b1);
         chk("tbl_valid", {31'd0, out_valid_o}, {31'd0, tbl[i].ev});
         if (tbl[i].ev) begin
            chk("tbl_id", 32'(out_id_o), 32'(tbl[i].eid));
            chk("tbl_cnt", 32'(out_cnt_o), 32'(tbl[i].ecnt));
            chk("tbl_last", {31'd0, out_last_o}, {31'd0, tbl[i].elast});
            chk("tbl_ovf", {31'd0, out_ovf_o}, 32'd0);
         end
      end

      // Counter overflow: 257 pulses
      step('0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 257; i++) step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
      step('0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef HPDCACHE_TB_PERF_SATURATE_EN
      chk("ovf_cnt", 32'(out_cnt_o), 32'd255);
`else
      chk("ovf_cnt", 32'(out_cnt_o), 32'd1);
`endif
      chk("ovf_flag", {31'd0, out_ovf_o}, 32'd1);
      drain();

      // Backpressure on entry 1
      step('0, 1'b0, 1'b1, 1'b0, 1'b1);
      step('0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step('0, 1'b0, 1'b0, 1'b0, 1'b1);
         chk("bp_hold_id", 32'(out_id_o), 32'd1);
      end
      for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("bp_done", {31'd0, out_valid_o}, 32'd0);

      // Snapshot request during STREAM is ignored; live counting continues
      step(4'b0010, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) step(4'(i[0] << 1), 1'b0, 1'b1, i[0], 1'b1);
      drain();
      step('0, 1'b0, 1'b1, 1'b1, 1'b1);
      drain();

      // Clear beats event; snapshot with clear shows pre-clear values
      step(4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
      step(4'b1000, 1'b1, 1'b0, 1'b0, 1'b1);
      step(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
      step('0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("clr_snap_cnt", 32'(out_cnt_o), 32'd1);
      drain();
      step('0, 1'b0, 1'b1, 1'b1, 1'b1);
      drain();

      // Reset mid-stream at id 2
      step(4'b0101, 1'b0, 1'b1, 1'b1, 1'b1);
      step('0, 1'b0, 1'b0, 1'b1, 1'b1);
      step('0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("rst_mid_id", 32'(out_id_o), 32'd2);
      step('0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("rst_mid_valid", {31'd0, out_valid_o}, 32'd0);
      step('0, 1'b0, 1'b1, 1'b1, 1'b1);
      drain();

      // Random stimulus
      for (int i = 0; i < 3000; i++) begin
         step(4'($urandom), ($urandom % 400) == 0, ($urandom % 6) == 0,
              ($urandom % 4) != 0, ($urandom % 500) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
